// File: rtl/water_inlet_arbiter_pkg.sv
// water_inlet_arbiter_pkg: shared FSM state encodings and default timing constants for the inlet arbiter
package water_inlet_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_e;
   localparam int DEF_MAX_FILL_TICKS = 10;
   localparam int DEF_GAP_CYCLES     = 3;
endpackage

// File: rtl/water_inlet_arbiter_rr_picker.sv
// water_inlet_arbiter_rr_picker: combinational round-robin pick of the first eligible index at or after ptr
//  elig  : eligible request mask
//  ptr   : round-robin start index (< N)
//  found : some bit of elig is set
//  idx   : chosen index, searched ptr, ptr+1, ... wrapping N-1 -> 0
module water_inlet_arbiter_rr_picker #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] c;
   always_comb begin
      found = 1'b0;
      idx   = '0;
      c     = ptr;
      for (int j = 0; j < N; j++) begin
         if (!found && elig[c]) begin
            found = 1'b1;
            idx   = c;
         end
         c = (c == IW'(N - 1)) ? '0 : c + 1'b1;
      end
   end
endmodule

// File: rtl/water_inlet_arbiter.sv
// water_inlet_arbiter: round-robin owner of one building water inlet valve shared by N washing machines
//  clk, rst   : clock, synchronous active-high reset
//  tick       : one-cycle timer pulse counting fill time
//  enable     : allows new grants (an active grant is never revoked by it)
//  fill_req   : level request per machine
//  fault_clr  : pulse clears the matching sticky fault
//  fill_gnt   : registered one-hot-or-zero grant
//  valve_open : inlet valve open (|fill_gnt)
//  valve_sel  : current or last owner index
//  fault      : sticky per-machine fill timeout
//  busy       : arbiter is granting or in the settle gap
module water_inlet_arbiter
   import water_inlet_arbiter_pkg::*;
#(
   parameter  int N_MACHINES     = 4,
   parameter  int MAX_FILL_TICKS = DEF_MAX_FILL_TICKS,
   parameter  int GAP_CYCLES     = DEF_GAP_CYCLES,
   localparam int IW             = $clog2(N_MACHINES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  enable,
   input  logic [N_MACHINES-1:0] fill_req,
   input  logic [N_MACHINES-1:0] fault_clr,
   output logic [N_MACHINES-1:0] fill_gnt,
   output logic                  valve_open,
   output logic [IW-1:0]         valve_sel,
   output logic [N_MACHINES-1:0] fault,
   output logic                  busy
);
   localparam int TW = $clog2(MAX_FILL_TICKS + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] T_LIM = TW'(MAX_FILL_TICKS);
   localparam logic [GW-1:0] G_LIM = GW'(GAP_CYCLES);

   arb_state_e            state_q, state_d;
   logic [N_MACHINES-1:0] gnt_q, gnt_d, fault_q, fault_d, set_f, elig;
   logic [IW-1:0]         sel_q, sel_d, rr_q, rr_d, pick;
   logic [TW-1:0]         tick_q, tick_d, tick_nx;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  found;

   assign elig = fill_req & ~fault_q;

   water_inlet_arbiter_rr_picker #(.N(N_MACHINES)) u_pick (
      .elig  (elig),
      .ptr   (rr_q),
      .found (found),
      .idx   (pick)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      tick_d  = tick_q;
      gap_d   = gap_q;
      set_f   = '0;
      tick_nx = (tick_q == T_LIM) ? tick_q : tick_q + 1'b1;
      case (state_q)
         ARB_IDLE:
            if (enable && found) begin
               state_d = ARB_GRANT;
               gnt_d   = N_MACHINES'(1) << pick;
               sel_d   = pick;
               tick_d  = '0;
            end
         ARB_GRANT:
            // A request drop wins over a coincident final tick, so fault is only set while still requesting
            if (!fill_req[sel_q] || (tick && tick_nx == T_LIM)) begin
               state_d = ARB_GAP;
               gnt_d   = '0;
               gap_d   = '0;
               rr_d    = (sel_q == IW'(N_MACHINES - 1)) ? '0 : sel_q + 1'b1;
               set_f   = fill_req[sel_q] ? gnt_q : '0;
            end else if (tick) begin
               tick_d = tick_nx;
            end
         ARB_GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q + 1'b1 == G_LIM) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
      fault_d = (fault_q & ~fault_clr) | set_f;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         rr_q    <= '0;
         fault_q <= '0;
         tick_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
         fault_q <= fault_d;
         tick_q  <= tick_d;
         gap_q   <= gap_d;
      end
   end

   assign fill_gnt   = gnt_q;
   assign valve_open = |gnt_q;
   assign valve_sel  = sel_q;
   assign fault      = fault_q;
   assign busy       = state_q != ARB_IDLE;
endmodule

// File: tb/tb_water_inlet_arbiter.sv
// tb_water_inlet_arbiter: scoreboard bench for the inlet arbiter; expected grant order queued, popped on each new grant
module tb_water_inlet_arbiter;
   logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, enable = 1'b1;
   logic [3:0] fill_req = '0, fault_clr = '0;
   logic [3:0] fill_gnt, fault;
   logic       valve_open, busy;
   logic [1:0] valve_sel;
   int         n_cmp = 0, n_err = 0;
   int         exp_q[$];
   int         e;
   logic [3:0] prev_gnt = '0;
   int         idle_run = 100;

   water_inlet_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .enable     (enable),
      .fill_req   (fill_req),
      .fault_clr  (fault_clr),
      .fill_gnt   (fill_gnt),
      .valve_open (valve_open),
      .valve_sel  (valve_sel),
      .fault      (fault),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_gnt = '0;
         idle_run = 100;
      end else begin
         n_cmp++;
         if ($countones(fill_gnt) > 1 || valve_open !== (|fill_gnt) ||
             (fill_gnt != 0 && prev_gnt != 0 && fill_gnt != prev_gnt)) begin
            n_err++;
            $display("FAIL grant_invariant: fill_gnt=%b prev=%b valve_open=%b, need one-hot-or-zero, valve_open=|gnt, no direct handover",
                     fill_gnt, prev_gnt, valve_open);
         end
         if (fill_gnt != 0 && prev_gnt == 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_grant: fill_gnt=%b, none expected", fill_gnt);
            end else begin
               e = exp_q.pop_front();
               if (fill_gnt !== 4'(1 << e) || valve_sel !== 2'(e) || idle_run < 3) begin
                  n_err++;
                  $display("FAIL grant_order: fill_gnt=%b valve_sel=%0d idle_clks=%0d, need gnt=%b sel=%0d idle>=3",
                           fill_gnt, valve_sel, idle_run, 4'(1 << e), e);
               end
            end
         end
         idle_run = (fill_gnt == 0) ? idle_run + 1 : 0;
         prev_gnt = fill_gnt;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_pulse();
      cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   task automatic apply_reset();
      cyc();
      rst = 1'b1;
      fill_req = '0;
      fault_clr = '0;
      tick = 1'b0;
      enable = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic wait_gnt(input int k, input string nm);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         hit = fill_gnt[k];
      end
      n_cmp++;
      if (!hit) begin
         n_err++;
         $display("FAIL %s: grant to %0d not seen within 40 clks, fill_gnt=%b", nm, k, fill_gnt);
      end
   endtask

   task automatic wait_idle(input string nm);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         hit = !busy;
      end
      n_cmp++;
      if (!hit) begin
         n_err++;
         $display("FAIL %s: busy still %b after 40 clks", nm, busy);
      end
   endtask

   task automatic test_reset();
      cyc();
      cyc();
      n_cmp++;
      if (fill_gnt !== 0 || valve_open !== 0 || valve_sel !== 0 || fault !== 0 || busy !== 0) begin
         n_err++;
         $display("FAIL reset_state: gnt=%b open=%b sel=%0d fault=%b busy=%b, need all 0",
                  fill_gnt, valve_open, valve_sel, fault, busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      exp_q.push_back(0);
      cyc();
      fill_req = 4'b0001;
      @(negedge clk);
      n_cmp++;
      if (fill_gnt !== 4'b0000) begin
         n_err++;
         $display("FAIL basic_latency: gnt=%b before grant edge, need 0000", fill_gnt);
      end
      @(negedge clk);
      n_cmp++;
      if (fill_gnt !== 4'b0001 || valve_open !== 1 || valve_sel !== 0 || busy !== 1) begin
         n_err++;
         $display("FAIL basic_grant: gnt=%b open=%b sel=%0d busy=%b, need 0001/1/0/1",
                  fill_gnt, valve_open, valve_sel, busy);
      end
      repeat (3) cyc();
      fill_req = 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (fill_gnt !== 4'b0001) begin
         n_err++;
         $display("FAIL basic_hold: gnt=%b before release edge, need 0001", fill_gnt);
      end
      @(negedge clk);
      n_cmp++;
      if (fill_gnt !== 4'b0000 || busy !== 1) begin
         n_err++;
         $display("FAIL basic_release: gnt=%b busy=%b, need 0000/1", fill_gnt, busy);
      end
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1) begin
         n_err++;
         $display("FAIL basic_gap: busy=%b in third gap clk, need 1", busy);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 0) begin
         n_err++;
         $display("FAIL basic_idle: busy=%b after 3 gap clks, need 0", busy);
      end
   endtask

   task automatic test_round_robin();
      int k;
      apply_reset();
      for (int i = 0; i < 5; i++) exp_q.push_back(i % 4);
      cyc();
      fill_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         k = i % 4;
         wait_gnt(k, "rr_wait");
         repeat (2) tick_pulse();
         cyc();
         fill_req[k] = 1'b0;
         @(negedge clk);
         @(negedge clk);
         n_cmp++;
         if (fill_gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL rr_release: owner %0d gnt=%b after req drop, need 0000", k, fill_gnt);
         end
         if (i < 4) begin
            cyc();
            fill_req[k] = 1'b1;
         end
      end
      cyc();
      fill_req = 4'b0000;
      wait_idle("rr_idle");
   endtask

   task automatic test_timeout();
      apply_reset();
      exp_q.push_back(2);
      cyc();
      fill_req = 4'b0100;
      wait_gnt(2, "to_wait");
      repeat (9) tick_pulse();
      n_cmp++;
      if (fault !== 4'b0000 || fill_gnt !== 4'b0100) begin
         n_err++;
         $display("FAIL to_9ticks: fault=%b gnt=%b, need 0000/0100", fault, fill_gnt);
      end
      tick_pulse();
      n_cmp++;
      if (fault !== 4'b0100 || fill_gnt !== 4'b0000 || busy !== 1) begin
         n_err++;
         $display("FAIL to_10ticks: fault=%b gnt=%b busy=%b, need 0100/0000/1", fault, fill_gnt, busy);
      end
      repeat (12) @(negedge clk);
      n_cmp++;
      if (fill_gnt !== 4'b0000 || busy !== 0 || fault !== 4'b0100) begin
         n_err++;
         $display("FAIL to_skip: gnt=%b busy=%b fault=%b, need 0000/0/0100", fill_gnt, busy, fault);
      end
      exp_q.push_back(2);
      cyc();
      fault_clr = 4'b0100;
      cyc();
      fault_clr = 4'b0000;
      wait_gnt(2, "to_regrant");
      n_cmp++;
      if (fault !== 4'b0000) begin
         n_err++;
         $display("FAIL to_clear: fault=%b, need 0000", fault);
      end
      cyc();
      fill_req = 4'b0000;
      wait_idle("to_idle");
   endtask

   task automatic test_coincident();
      apply_reset();
      exp_q.push_back(0);
      cyc();
      fill_req = 4'b0001;
      wait_gnt(0, "co_wait");
      repeat (9) tick_pulse();
      cyc();
      tick = 1'b1;
      fill_req = 4'b0000;
      cyc();
      tick = 1'b0;
      n_cmp++;
      if (fault !== 4'b0000 || fill_gnt !== 4'b0000 || busy !== 1) begin
         n_err++;
         $display("FAIL co_release: fault=%b gnt=%b busy=%b, need 0000/0000/1", fault, fill_gnt, busy);
      end
      wait_idle("co_idle");
   endtask

   task automatic test_enable();
      apply_reset();
      cyc();
      enable = 1'b0;
      fill_req = 4'b0001;
      repeat (8) @(negedge clk);
      n_cmp++;
      if (fill_gnt !== 4'b0000 || busy !== 0) begin
         n_err++;
         $display("FAIL en_block: gnt=%b busy=%b with enable=0, need 0000/0", fill_gnt, busy);
      end
      exp_q.push_back(0);
      cyc();
      enable = 1'b1;
      wait_gnt(0, "en_wait");
      cyc();
      enable = 1'b0;
      fill_req = 4'b0011;
      repeat (3) tick_pulse();
      n_cmp++;
      if (fill_gnt !== 4'b0001) begin
         n_err++;
         $display("FAIL en_persist: gnt=%b after enable drop, need 0001", fill_gnt);
      end
      cyc();
      fill_req = 4'b0010;
      wait_idle("en_release");
      repeat (6) @(negedge clk);
      n_cmp++;
      if (fill_gnt !== 4'b0000 || busy !== 0) begin
         n_err++;
         $display("FAIL en_no_new: gnt=%b busy=%b, need 0000/0", fill_gnt, busy);
      end
      exp_q.push_back(1);
      cyc();
      enable = 1'b1;
      wait_gnt(1, "en_rewait");
      cyc();
      fill_req = 4'b0000;
      wait_idle("en_idle");
   endtask

   task automatic test_reset_mid_grant();
      apply_reset();
      exp_q.push_back(1);
      cyc();
      fill_req = 4'b0010;
      wait_gnt(1, "rm_wait1");
      repeat (10) tick_pulse();
      n_cmp++;
      if (fault !== 4'b0010) begin
         n_err++;
         $display("FAIL rm_fault: fault=%b, need 0010", fault);
      end
      exp_q.push_back(0);
      cyc();
      fill_req = 4'b0001;
      wait_gnt(0, "rm_wait0");
      cyc();
      rst = 1'b1;
      fill_req = 4'b0110;
      cyc();
      n_cmp++;
      if (fill_gnt !== 0 || valve_open !== 0 || valve_sel !== 0 || fault !== 0 || busy !== 0) begin
         n_err++;
         $display("FAIL rm_reset: gnt=%b open=%b sel=%0d fault=%b busy=%b, need all 0",
                  fill_gnt, valve_open, valve_sel, fault, busy);
      end
      exp_q.push_back(1);
      cyc();
      rst = 1'b0;
      wait_gnt(1, "rm_from0");
      cyc();
      fill_req = 4'b0000;
      wait_idle("rm_idle");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_timeout();
      test_coincident();
      test_enable();
      test_reset_mid_grant();
      repeat (4) cyc();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d expected grants never seen, need 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
